reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
Control FSM that drives the ms countdown timer for the reaction-time game. On a start press it loads a pseudo-random delay into the timer and waits for expiry, then lights the GO LED. It measures the player's reaction in ms until the button press and reports the result, a false start, or a timeout. Sits directly upstream of the timer: it drives stop/start_value/enable and consumes timer_value.

Parameters:
MAX_MS, 16, timer range; W = $clog2(MAX_MS) is the timer value width; W must be <= 16
CLKS_PER_MS, 50000, clock cycles per ms tick of the reaction counter
MAX_REACT_MS, 1000, reaction timeout in ms; RW = $clog2(MAX_REACT_MS+1)
LFSR_SEED, 16'hACE1, reset value of the delay LFSR; must be nonzero

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, already debounced: begin a round
button  input  1  single-cycle pulse, already debounced: player response
timer_value  input  W  current timer count, from the timer
timer_stop  output  1  to timer: 1 loads timer_start_value
timer_enable  output  1  to timer: count down
timer_start_value  output  W  delay to load, in ms
led_go  output  1  GO indicator
reaction_ms  output  RW  last measured reaction time
result_valid  output  1  one-cycle pulse when reaction_ms is updated
false_start  output  1  one-cycle pulse on an early press
timeout  output  1  one-cycle pulse when no press arrives within MAX_REACT_MS

Behaviour:
- Reset (async, rst_n=0): state IDLE; timer_stop=1; timer_enable=0; timer_start_value=0; led_go=0; reaction_ms=0; all pulses 0; LFSR=LFSR_SEED; ms prescaler and reaction counter = 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle in every state except reset.
- IDLE: timer_stop=1, timer_enable=0. A start pulse latches d = LFSR[W-1:0], or 1 if that value is 0, into timer_start_value, then goes to LOAD. button is ignored.
- LOAD: exactly 2 cycles with timer_stop=1 and timer_enable=0. This guarantees the timer has reloaded before expiry is checked. Then go to WAIT.
- WAIT: timer_stop=0, timer_enable=1. If button=1, pulse false_start and go to IDLE; this takes priority over expiry in the same cycle. Otherwise, if timer_value==0, go to GO and clear the prescaler and reaction counter.
- GO: led_go=1, timer_enable=0, timer_stop=1. The prescaler counts 0..CLKS_PER_MS-1; on wrap the reaction counter increments.
  - button=1: reaction_ms <= counter, pulse result_valid, go to IDLE. The button is checked before the increment; a press in the first ms reports 0.
  - Counter reaching MAX_REACT_MS: pulse timeout, go to IDLE, reaction_ms unchanged.
  - Button press and timeout in the same cycle: button wins.
- led_go is 0 in every state except GO and drops on the cycle IDLE is entered.
- A start pulse in LOAD/WAIT/GO is ignored; no restart mid-round.
- Reset mid-round returns to IDLE immediately; no pulse is emitted.
- reaction_ms holds its value between results.

Optional Feature:
HIGH_SCORE_EN. When defined, adds output best_ms (RW bits), which resets to all-ones. On each result_valid, best_ms <= min(best_ms, measured value). False starts and timeouts never update it. When undefined, the port and register do not exist and all other behaviour is identical.

Test Plan:
- Bench: MAX_MS=16, CLKS_PER_MS=10, MAX_REACT_MS=20.
- Reset release, no stimulus -> IDLE; timer_stop=1, led_go=0, reaction_ms=0 for 100 cycles.
- Start pulse, timer model counts down to 0, button pressed 35 cycles after led_go rises -> timer_start_value equals the LFSR model (nonzero, <16); stop high for 2 cycles; result_valid pulse once; reaction_ms=3; led_go low next cycle.
- Start, button during WAIT with timer_value=2 -> false_start pulse, led_go never asserted, state IDLE. Repeat with button and expiry in the same cycle -> false_start, not GO.
- Start, expiry, no button for 200 cycles -> timeout pulse at counter 20, reaction_ms keeps its previous value, led_go low.
- Start pulse during GO, then rst_n low mid-GO -> second start ignored; reset forces IDLE and led_go=0 asynchronously, with no pulses.
- HIGH_SCORE_EN defined, results 5, 3, 7 -> best_ms = 5, then 3, then 3; a false start leaves best_ms=3.

Source files
------------

// File: rtl/reaction_timer_ctrl_if.sv
// Signal bundle between the reaction-timer controller, its player inputs and the ms timer.
// When HIGH_SCORE_EN is defined the bundle also carries best_ms.
interface reaction_timer_ctrl_if #(
  parameter int W  = 4,
  parameter int RW = 10
);
  logic          start;
  logic          button;
  logic [W-1:0]  timer_value;
  logic          timer_stop;
  logic          timer_enable;
  logic [W-1:0]  timer_start_value;
  logic          led_go;
  logic [RW-1:0] reaction_ms;
  logic          result_valid;
  logic          false_start;
  logic          timeout;
`ifdef HIGH_SCORE_EN
  logic [RW-1:0] best_ms;
`endif

  modport master (
    output start, button, timer_value,
`ifdef HIGH_SCORE_EN
    input  best_ms,
`endif
    input  timer_stop, timer_enable, timer_start_value, led_go,
    input  reaction_ms, result_valid, false_start, timeout
  );

  modport slave (
    input  start, button, timer_value,
`ifdef HIGH_SCORE_EN
    output best_ms,
`endif
    output timer_stop, timer_enable, timer_start_value, led_go,
    output reaction_ms, result_valid, false_start, timeout
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random delay via the ms timer, GO LED, reaction measurement.
// Optional HIGH_SCORE_EN macro adds best_ms, the lowest reaction time since reset.
module reaction_timer_ctrl #(
  parameter int          MAX_MS       = 16,
  parameter int          CLKS_PER_MS  = 50000,
  parameter int          MAX_REACT_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst_n,
  reaction_timer_ctrl_if.slave bus
);
  localparam int W  = $clog2(MAX_MS);
  localparam int RW = $clog2(MAX_REACT_MS + 1);
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GO} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [W-1:0]  start_val_q, start_val_d;
  logic          load_cnt_q, load_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] ms_q, ms_d;
  logic [RW-1:0] react_q, react_d;
  logic          rv_q, rv_d, fs_q, fs_d, to_q, to_d;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  always_comb begin
    state_d     = state_q;
    start_val_d = start_val_q;
    load_cnt_d  = load_cnt_q;
    presc_d     = presc_q;
    ms_d        = ms_q;
    react_d     = react_q;
    rv_d        = 1'b0;
    fs_d        = 1'b0;
    to_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_val_d = (lfsr_q[W-1:0] == '0) ? W'(1) : lfsr_q[W-1:0];
          load_cnt_d  = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        load_cnt_d = 1'b1;
        if (load_cnt_q) state_d = WAIT;
      end
      WAIT: begin
        if (bus.button) begin
          fs_d    = 1'b1;
          state_d = IDLE;
        end else if (bus.timer_value == '0) begin
          presc_d = '0;
          ms_d    = '0;
          state_d = GO;
        end
      end
      GO: begin
        // The press is judged against the count before this cycle's increment
        if (bus.button) begin
          react_d = ms_q;
          rv_d    = 1'b1;
          state_d = IDLE;
        end else if (ms_q == RW'(MAX_REACT_MS)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (presc_q == PW'(CLKS_PER_MS - 1)) begin
          presc_d = '0;
          ms_d    = ms_q + RW'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      start_val_q <= '0;
      load_cnt_q  <= 1'b0;
      presc_q     <= '0;
      ms_q        <= '0;
      react_q     <= '0;
      rv_q        <= 1'b0;
      fs_q        <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      start_val_q <= start_val_d;
      load_cnt_q  <= load_cnt_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      react_q     <= react_d;
      rv_q        <= rv_d;
      fs_q        <= fs_d;
      to_q        <= to_d;
    end
  end

  // Timer control and LED decode straight from state so reset clears them asynchronously
  assign bus.timer_stop        = (state_q != WAIT);
  assign bus.timer_enable      = (state_q == WAIT);
  assign bus.timer_start_value = start_val_q;
  assign bus.led_go            = (state_q == GO);
  assign bus.reaction_ms       = react_q;
  assign bus.result_valid      = rv_q;
  assign bus.false_start       = fs_q;
  assign bus.timeout           = to_q;

`ifdef HIGH_SCORE_EN
  logic [RW-1:0] best_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     best_q <= '1;
    else if (rv_d && ms_q < best_q) best_q <= ms_q;
  end

  assign bus.best_ms = best_q;
`endif
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: directed table, hand sequences, randomized rounds vs round-level model.
module tb_reaction_timer_ctrl;
  localparam int MAX_MS  = 16;
  localparam int CPM     = 10;
  localparam int MAXR    = 20;
  localparam int W       = $clog2(MAX_MS);
  localparam int RW      = $clog2(MAXR + 1);
  localparam int GO_MAX  = MAXR * CPM;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int K_RES = 0, K_FS = 1, K_TO = 2;
  localparam int M_GO = 0, M_WAIT = 1, M_EXP = 2, M_NONE = 3, M_LOAD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reaction_timer_ctrl_if #(.W(W), .RW(RW)) bus ();

  reaction_timer_ctrl #(
    .MAX_MS(MAX_MS), .CLKS_PER_MS(CPM), .MAX_REACT_MS(MAXR), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   lfsr_m;
  logic [W-1:0]  tv;
  logic [RW-1:0] m_react;
  logic [RW-1:0] m_best;
  bit            noise;

  typedef struct {
    int mode; int off; int min_d; int kind; int react; int best; int tv;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int dval(input logic [15:0] s);
    return (s[W-1:0] == '0) ? 1 : int'(s[W-1:0]);
  endfunction

  // One clock: ms-timer neighbour model and LFSR shadow advance on the edge
  task automatic tick();
    logic stp, en;
    logic [W-1:0] sv;
    stp = bus.timer_stop; en = bus.timer_enable; sv = bus.timer_start_value;
    @(posedge clk);
    if (rst_n) lfsr_m = lfsr_next(lfsr_m);
    #1;
    if (stp) tv = sv;
    else if (en && tv != '0) tv = tv - 1'b1;
    bus.timer_value = tv;
    bus.start = 1'b0;
    bus.button = 1'b0;
  endtask

  // Round timeline from the start-press cycle 0: LOAD 1..2, WAIT 3..3+d, GO from 4+d
  task automatic run_round(input int press_c, input string nm,
                           output int got_kind, output int press_tv);
    int d, mk, mcyc, mgo, got_cyc, go_cnt, stop_bad, npulse, tsv;
    d = dval(lfsr_m);
    if (press_c >= 3 && press_c <= 3 + d) begin
      mk = K_FS; mcyc = press_c + 1; mgo = 0;
    end else if (press_c >= 4 + d && press_c <= 4 + d + GO_MAX) begin
      mk = K_RES; mcyc = press_c + 1; mgo = press_c - 3 - d;
      m_react = RW'((press_c - 4 - d) / CPM);
      if (m_react < m_best) m_best = m_react;
    end else begin
      mk = K_TO; mcyc = 5 + d + GO_MAX; mgo = GO_MAX + 1;
    end
    got_kind = -1; got_cyc = -1; go_cnt = 0; stop_bad = 0; npulse = 0;
    press_tv = -1; tsv = -1;
    for (int c = 0; c < 4 + d + GO_MAX + 20; c++) begin
      bus.start  = (c == 0) || (noise && $urandom_range(0, 15) == 0);
      bus.button = (c == press_c);
      if (c == press_c) press_tv = int'(bus.timer_value);
      if (bus.led_go) go_cnt++;
      if ((c == 1 || c == 2) && (!bus.timer_stop || bus.timer_enable)) stop_bad++;
      if (c == 3 && (bus.timer_stop || !bus.timer_enable)) stop_bad++;
      if (c == 1) tsv = int'(bus.timer_start_value);
      tick();
      npulse = int'(bus.result_valid) + int'(bus.false_start) + int'(bus.timeout);
      if (npulse != 0) begin
        got_kind = bus.result_valid ? K_RES : (bus.false_start ? K_FS : K_TO);
        got_cyc = c + 1;
        break;
      end
    end
    chk({nm, "_kind"}, got_kind, mk);
    chk({nm, "_npulse"}, npulse, 1);
    chk({nm, "_cycle"}, got_cyc, mcyc);
    chk({nm, "_golen"}, go_cnt, mgo);
    chk({nm, "_load_stop"}, stop_bad, 0);
    chk({nm, "_start_value"}, tsv, d);
    chk({nm, "_react"}, bus.reaction_ms, m_react);
    chk({nm, "_led_off"}, bus.led_go, 0);
`ifdef HIGH_SCORE_EN
    chk({nm, "_best"}, bus.best_ms, m_best);
`endif
    tick();
    chk({nm, "_pulse_drop"}, {bus.result_valid, bus.false_start, bus.timeout}, 0);
  endtask

  task automatic do_reset_release();
    @(posedge clk);
    #1 rst_n = 1'b1;
    lfsr_m = SEED; tv = '0; bus.timer_value = '0;
    m_react = '0; m_best = '1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, ptv, d, p, bad, n;
    tbl[0]  = '{M_GO,   55,  0, K_RES, 5,  5, -1};
    tbl[1]  = '{M_GO,   35,  0, K_RES, 3,  3, -1};
    tbl[2]  = '{M_GO,   75,  0, K_RES, 7,  3, -1};
    tbl[3]  = '{M_WAIT,  0,  0, K_FS,  7,  3, -1};
    tbl[4]  = '{M_EXP,  -2,  2, K_FS,  7,  3,  2};
    tbl[5]  = '{M_EXP,   0,  0, K_FS,  7,  3,  0};
    tbl[6]  = '{M_NONE,  0,  0, K_TO,  7,  3, -1};
    tbl[7]  = '{M_GO,  200,  0, K_RES, 20, 3, -1};
    tbl[8]  = '{M_GO,    9,  0, K_RES, 0,  0, -1};
    tbl[9]  = '{M_GO,   10,  0, K_RES, 1,  0, -1};
    tbl[10] = '{M_GO,  201,  0, K_TO,  1,  0, -1};
    tbl[11] = '{M_LOAD,  0,  0, K_TO,  1,  0, -1};

    rst_n = 1'b0; noise = 1'b0;
    bus.start = 1'b0; bus.button = 1'b0; bus.timer_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stop", bus.timer_stop, 1);
    chk("rst_enable", bus.timer_enable, 0);
    chk("rst_start_value", bus.timer_start_value, 0);
    chk("rst_led", bus.led_go, 0);
    chk("rst_react", bus.reaction_ms, 0);
    chk("rst_pulses", {bus.result_valid, bus.false_start, bus.timeout}, 0);
    rst_n = 1'b1;
    lfsr_m = SEED; tv = '0; m_react = '0; m_best = '1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.timer_stop || bus.timer_enable || bus.led_go || bus.reaction_ms != '0 ||
          bus.result_valid || bus.false_start || bus.timeout) bad++;
    end
    chk("idle_100_cycles", bad, 0);

    for (int i = 0; i < 12; i++) begin
      n = 0;
      while (dval(lfsr_m) < tbl[i].min_d && n < 64) begin tick(); n++; end
      d = dval(lfsr_m);
      case (tbl[i].mode)
        M_GO:    p = 4 + d + tbl[i].off;
        M_WAIT:  p = 3 + tbl[i].off;
        M_EXP:   p = 3 + d + tbl[i].off;
        M_LOAD:  p = 1 + tbl[i].off;
        default: p = -1;
      endcase
      run_round(p, $sformatf("vec%0d", i), kind, ptv);
      chk($sformatf("vec%0d_tbl_kind", i), kind, tbl[i].kind);
      chk($sformatf("vec%0d_tbl_react", i), bus.reaction_ms, tbl[i].react);
`ifdef HIGH_SCORE_EN
      chk($sformatf("vec%0d_tbl_best", i), bus.best_ms, tbl[i].best);
`endif
      if (tbl[i].tv >= 0) chk($sformatf("vec%0d_tbl_tv", i), ptv, tbl[i].tv);
    end

    // Second start in GO is ignored; reset mid-GO clears everything at once
    d = dval(lfsr_m);
    bus.start = 1'b1; tick();
    n = 0;
    while (!bus.led_go && n < 100) begin tick(); n++; end
    chk("midgo_reached", bus.led_go, 1);
    repeat (5) tick();
    bus.start = 1'b1; tick();
    repeat (3) tick();
    chk("midgo_restart_ignored", bus.led_go, 1);
    chk("midgo_start_value_kept", bus.timer_start_value, d);
    #3 rst_n = 1'b0;
    #1;
    chk("midgo_rst_led", bus.led_go, 0);
    chk("midgo_rst_stop", bus.timer_stop, 1);
    chk("midgo_rst_react", bus.reaction_ms, 0);
    chk("midgo_rst_pulses", {bus.result_valid, bus.false_start, bus.timeout}, 0);
    repeat (2) @(posedge clk);
    do_reset_release();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.result_valid || bus.false_start || bus.timeout || bus.led_go ||
          !bus.timer_stop) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    run_round(4 + dval(lfsr_m) + 35, "post_rst", kind, ptv);
    chk("post_rst_tbl_react", bus.reaction_ms, 3);

    noise = 1'b1;
    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(0, 5));
      for (int g = 0; g < n; g++) begin
        bus.button = ($urandom_range(0, 1) == 1);
        tick();
      end
      d = dval(lfsr_m);
      case ($urandom_range(0, 3))
        0:       p = int'($urandom_range(3, 3 + d));
        1, 2:    p = 4 + d + int'($urandom_range(0, GO_MAX));
        default: p = int'($urandom_range(0, 4 + d + GO_MAX + 10));
      endcase
      run_round(p, $sformatf("rnd%0d", r), kind, ptv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
